tx_fifo_arbiter: RTL and testbench

- Shares the single 8-bit TX FIFO that feeds the UART serial transmitter among N_REQ byte sources, such as the tape-capture stream and the debug/status message generator.
- Round-robin arbitration at packet granularity: once a source is granted, it keeps the FIFO write port until it transfers a byte flagged last, or until it stalls past a timeout.
- Sits between the byte producers and the FIFO write side; the UART reader side is untouched.

---
 rtl/tx_arb_pkg.sv | 14 +
 rtl/tx_fifo_arbiter_rr_pick.sv | 31 +++
 rtl/tx_fifo_arbiter.sv | 124 ++++++++++++
 tb/tb_tx_fifo_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// rtl/tx_arb_pkg.sv - shared state encoding and constants for the TX FIFO arbiter
package tx_arb_pkg;

    // TAG only exists in builds that emit a packet tag byte
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TAG    = 2'd1,
        STREAM = 2'd2
    } state_t;

    localparam logic [3:0] TAG_MAGIC_DFLT = 4'hA;
    localparam int         STALL_W        = 16;

endpackage

// File: rtl/tx_fifo_arbiter_rr_pick.sv
// rtl/tx_fifo_arbiter_rr_pick.sv - combinational round-robin selector
module rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  last,
    output logic [ID_W-1:0]  winner,
    output logic             any
);

    int pos;

    // search last+1, last+2, ... (mod N_REQ); first requester found wins
    always_comb begin
        winner = '0;
        any    = 1'b0;
        pos    = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            pos = int'(last) + k;
            if (pos >= N_REQ) pos = pos - N_REQ;
            for (int j = 0; j < N_REQ; j++) begin
                if (!any && j == pos && req[j]) begin
                    any    = 1'b1;
                    winner = ID_W'(j);
                end
            end
        end
    end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// rtl/tx_fifo_arbiter.sv - packet-granular round-robin arbiter for the UART TX FIFO write port
// Optional tag byte before each packet: define TX_ARB_TAG_EN.
module tx_fifo_arbiter
    import tx_arb_pkg::*;
#(
    parameter int          N_REQ          = 2,
    parameter int          ID_W           = 1,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000,
    parameter logic [3:0]  TAG_MAGIC      = TAG_MAGIC_DFLT
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ready,
    input  logic               i_fifo_full,
    output logic               o_fifo_wr_req,
    output logic [7:0]         o_fifo_wr_data,
    output logic [ID_W-1:0]    o_grant_id,
    output logic               o_busy,
    output logic               o_timeout
);

    state_t              state;
    state_t              next_state;
    logic [ID_W-1:0]     last_ptr;
    logic [ID_W-1:0]     pick;
    logic                any_req;
    logic [STALL_W-1:0]  stall_cnt;
    logic                valid_g;
    logic                last_g;
    logic [7:0]          data_g;
    logic                xfer;
    logic                stall;
    logic                timeout_hit;
    logic                pkt_end;

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req    (i_req_valid),
        .last   (last_ptr),
        .winner (pick),
        .any    (any_req)
    );

    assign valid_g     = i_req_valid[o_grant_id];
    assign last_g      = i_req_last[o_grant_id];
    assign data_g      = i_req_data[{o_grant_id, 3'b000} +: 8];
    assign xfer        = (state == STREAM) & valid_g & ~i_fifo_full;
    assign stall       = (state == STREAM) & ~valid_g & ~i_fifo_full;
    assign timeout_hit = stall & (TIMEOUT_CYCLES != 16'd0) &
                         (stall_cnt >= TIMEOUT_CYCLES - 16'd1);
    assign pkt_end     = (xfer & last_g) | timeout_hit;
    assign o_busy      = (state != IDLE);

    // state register
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= next_state;
    end

    // next state plus the write-side strobes; reset masks the combinational outputs
    always_comb begin
        next_state     = state;
        o_req_ready    = '0;
        o_fifo_wr_req  = 1'b0;
        o_fifo_wr_data = 8'h00;
        case (state)
            IDLE: begin
                if (any_req) begin
`ifdef TX_ARB_TAG_EN
                    next_state = TAG;
`else
                    next_state = STREAM;
`endif
                end
            end
            TAG: begin
                o_fifo_wr_req  = ~i_fifo_full;
                o_fifo_wr_data = {TAG_MAGIC, 4'(o_grant_id)};
                if (!i_fifo_full) next_state = STREAM;
            end
            STREAM: begin
                o_req_ready[o_grant_id] = ~i_fifo_full;
                o_fifo_wr_req           = valid_g & ~i_fifo_full;
                o_fifo_wr_data          = data_g;
                if (pkt_end) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
        if (i_reset) begin
            o_req_ready   = '0;
            o_fifo_wr_req = 1'b0;
        end
        if (!o_fifo_wr_req) o_fifo_wr_data = 8'h00;
    end

    // latch the arbitration winner; move the priority pointer when a packet ends
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_grant_id <= '0;
            last_ptr   <= ID_W'(N_REQ - 1);
        end else begin
            if (state == IDLE && any_req) o_grant_id <= pick;
            if (pkt_end)                  last_ptr   <= o_grant_id;
        end
    end

    // saturating stall counter; frozen while the FIFO is full so backpressure never times out
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            stall_cnt <= '0;
            o_timeout <= 1'b0;
        end else begin
            o_timeout <= timeout_hit;
            if (state != STREAM || xfer || timeout_hit) stall_cnt <= '0;
            else if (stall && stall_cnt != '1)          stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// tb/tb_tx_fifo_arbiter.sv - randomized self-checking bench for tx_fifo_arbiter
module tb_tx_fifo_arbiter;

    localparam int          N   = 3;
    localparam int          IDW = 2;
    localparam logic [15:0] T   = 16'd16;
`ifdef TX_ARB_TAG_EN
    localparam bit TAG_EN = 1'b1;
`else
    localparam bit TAG_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   valid;
    logic [8*N-1:0] data;
    logic [N-1:0]   last;
    logic [N-1:0]   ready;
    logic           full;
    logic           wr_req;
    logic [7:0]     wr_data;
    logic [IDW-1:0] grant;
    logic           busy;
    logic           tmo;

    always #5 clk = ~clk;

    tx_fifo_arbiter #(
        .N_REQ          (N),
        .ID_W           (IDW),
        .TIMEOUT_CYCLES (T),
        .TAG_MAGIC      (4'hA)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_req_valid    (valid),
        .i_req_data     (data),
        .i_req_last     (last),
        .o_req_ready    (ready),
        .i_fifo_full    (full),
        .o_fifo_wr_req  (wr_req),
        .o_fifo_wr_data (wr_data),
        .o_grant_id     (grant),
        .o_busy         (busy),
        .o_timeout      (tmo)
    );

    int n_cmp = 0;
    int n_mis = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // producers: per-source byte queues (circular) and idle-gap counters
    logic [7:0] pb [N][256];
    bit         pl [N][256];
    int         head [N];
    int         tail [N];
    int         gap  [N];

    task automatic push_byte(input int s, input logic [7:0] b, input bit l);
        pb[s][tail[s] % 256] = b;
        pl[s][tail[s] % 256] = l;
        tail[s]++;
    endtask

    // reference model: who owns the port, whether a tag is owed, rr history, quiet cycles
    int m_owner, m_prev, m_quiet, m_grant;
    bit m_tag, m_to;

    task automatic model_reset();
        m_owner = -1; m_prev = N - 1; m_quiet = 0; m_grant = 0; m_tag = 0; m_to = 0;
    endtask

    int  p_gap = 0, p_long = 0, p_full = 0, p_rst = 0;
    bit  force_full = 0, hold_rst = 0;
    int  n_to_seen = 0;
    logic [7:0] dut_log[$];
    logic [7:0] mdl_log[$];

    task automatic cycle();
        logic [N-1:0] e_ready;
        logic         e_wr;
        logic [7:0]   e_data;
        int           s, c;
        @(negedge clk);
        for (int k = 0; k < N; k++) begin
            if (gap[k] == 0 && p_gap > 0 && $urandom_range(0, 99) < p_gap)
                gap[k] = ($urandom_range(0, 99) < p_long) ? 20 : int'($urandom_range(1, 4));
            if (gap[k] > 0) begin
                gap[k]--;
                valid[k] = 1'b0;
                data[8*k +: 8] = 8'($urandom);
                last[k] = 1'($urandom);
            end else if (head[k] != tail[k]) begin
                valid[k] = 1'b1;
                data[8*k +: 8] = pb[k][head[k] % 256];
                last[k] = pl[k][head[k] % 256];
            end else begin
                valid[k] = 1'b0;
                data[8*k +: 8] = 8'($urandom);
                last[k] = 1'($urandom);
            end
        end
        full = force_full | ($urandom_range(0, 99) < p_full);
        rst  = hold_rst | (p_rst > 0 && $urandom_range(0, 999) < p_rst);
        if (rst) model_reset();
        #1;
        e_ready = '0; e_wr = 1'b0; e_data = 8'h00;
        if (!rst && m_owner >= 0) begin
            if (m_tag) begin
                e_wr = !full;
                if (e_wr) e_data = {4'hA, 4'(m_owner)};
            end else begin
                e_ready[m_owner] = !full;
                if (valid[m_owner] && !full) begin
                    e_wr = 1'b1;
                    e_data = data[8*m_owner +: 8];
                end
            end
        end
        check_eq("ready",   32'(ready),   32'(e_ready));
        check_eq("wr_req",  32'(wr_req),  32'(e_wr));
        check_eq("wr_data", 32'(wr_data), 32'(e_data));
        check_eq("grant",   32'(grant),   32'(m_grant));
        check_eq("busy",    32'(busy),    32'(m_owner >= 0));
        check_eq("timeout", 32'(tmo),     32'(m_to));
        if (tmo)    n_to_seen++;
        if (wr_req) dut_log.push_back(wr_data);
        if (e_wr)   mdl_log.push_back(e_data);
        @(posedge clk);
        if (!rst) begin
            m_to = 0;
            if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    c = (m_prev + i) % N;
                    if (m_owner < 0 && valid[c]) begin
                        m_owner = c; m_grant = c; m_tag = TAG_EN; m_quiet = 0;
                    end
                end
            end else if (m_tag) begin
                if (!full) m_tag = 0;
            end else if (!full) begin
                s = m_owner;
                if (valid[s]) begin
                    head[s]++;
                    m_quiet = 0;
                    if (last[s]) begin m_prev = s; m_owner = -1; end
                end else if (m_quiet == int'(T) - 1) begin
                    m_to = 1; m_prev = s; m_owner = -1; m_quiet = 0;
                end else begin
                    m_quiet++;
                end
            end
        end
    endtask

    // data bytes in the log, tag bytes removed
    task automatic data_after(input int base, output logic [7:0] q[$]);
        q = {};
        for (int i = base; i < dut_log.size(); i++)
            if (!(TAG_EN && dut_log[i][7:4] == 4'hA && dut_log[i][3:0] < 4'(N))) q.push_back(dut_log[i]);
    endtask

    initial begin
        int base, to0, h0, lim;
        logic [7:0] q[$];
        logic [7:0] exp_c[8];
        valid = '0; data = '0; last = '0; full = 1'b0; rst = 1'b1;
        for (int k = 0; k < N; k++) begin head[k] = 0; tail[k] = 0; gap[k] = 0; end
        model_reset();

        // reset state
        hold_rst = 1; cycle(); cycle(); hold_rst = 0;

        // single packet from src0
        base = dut_log.size();
        push_byte(0, 8'h11, 0); push_byte(0, 8'h22, 0); push_byte(0, 8'h33, 1);
        repeat (8) cycle();
        check_eq("single_len", 32'(dut_log.size() - base), TAG_EN ? 32'd4 : 32'd3);
        if (TAG_EN) check_eq("single_tag", 32'(dut_log[base]), 32'hA0);
        q = {};
        data_after(base, q);
        check_eq("single_b0", 32'(q[0]), 32'h11);
        check_eq("single_b1", 32'(q[1]), 32'h22);
        check_eq("single_b2", 32'(q[2]), 32'h33);

        // contention between src0 and src1
        hold_rst = 1; cycle(); hold_rst = 0;
        base = dut_log.size();
        push_byte(0, 8'h01, 0); push_byte(0, 8'h02, 1); push_byte(0, 8'h03, 0); push_byte(0, 8'h04, 1);
        push_byte(1, 8'h81, 0); push_byte(1, 8'h82, 1); push_byte(1, 8'h83, 0); push_byte(1, 8'h84, 1);
        repeat (24) cycle();
        exp_c = '{8'h01, 8'h02, 8'h81, 8'h82, 8'h03, 8'h04, 8'h83, 8'h84};
        data_after(base, q);
        check_eq("cont_len", 32'(q.size()), 32'd8);
        for (int i = 0; i < 8 && i < q.size(); i++) check_eq("cont_order", 32'(q[i]), 32'(exp_c[i]));

        // backpressure for 100 cycles mid-packet
        base = dut_log.size(); to0 = n_to_seen;
        for (int i = 0; i < 4; i++) push_byte(0, 8'h31 + 8'(i), i == 3);
        repeat (3) cycle();
        force_full = 1; repeat (100) cycle(); force_full = 0;
        repeat (10) cycle();
        check_eq("bp_no_timeout", 32'(n_to_seen - to0), 32'd0);
        data_after(base, q);
        check_eq("bp_len", 32'(q.size()), 32'd4);

        // timeout: src1 sends one byte then goes quiet; src0 waits
        hold_rst = 1; cycle(); hold_rst = 0;
        push_byte(1, 8'h41, 0); push_byte(1, 8'h42, 0); push_byte(1, 8'h43, 1);
        h0 = head[1]; lim = 0;
        while (head[1] == h0 && lim < 10) begin cycle(); lim++; end
        check_eq("tmo_setup", 32'(head[1] - h0), 32'd1);
        gap[1] = 40;
        push_byte(0, 8'h51, 0); push_byte(0, 8'h52, 1);
        base = dut_log.size(); to0 = n_to_seen;
        repeat (24) cycle();
        check_eq("tmo_pulses", 32'(n_to_seen - to0), 32'd1);
        data_after(base, q);
        check_eq("tmo_next_src0", 32'(q.size() > 0 ? q[0] : 8'h00), 32'h51);
        repeat (40) cycle();

        // reset during the second byte of a packet
        for (int i = 0; i < 4; i++) push_byte(0, 8'h61 + 8'(i), i == 3);
        push_byte(1, 8'h71, 0); push_byte(1, 8'h72, 1);
        h0 = head[0]; lim = 0;
        while (head[0] == h0 && lim < 10) begin cycle(); lim++; end
        check_eq("rst_setup", 32'(head[0] - h0), 32'd1);
        hold_rst = 1; cycle(); hold_rst = 0;
        base = dut_log.size();
        repeat (20) cycle();
        data_after(base, q);
        check_eq("rst_src0_first", 32'(q.size() > 0 ? q[0] : 8'h00), 32'h62);

        // randomized traffic with gaps, backpressure, stalls and rare resets
        p_gap = 10; p_long = 15; p_full = 20; p_rst = 3;
        repeat (1500) begin
            for (int k = 0; k < N; k++)
                if (tail[k] - head[k] < 4) begin
                    lim = $urandom_range(1, 4);
                    for (int i = 0; i < lim; i++) push_byte(k, 8'($urandom), i == lim - 1);
                end
            cycle();
        end
        p_gap = 0; p_full = 0; p_rst = 0;
        repeat (80) cycle();

        check_eq("log_len", 32'(dut_log.size()), 32'(mdl_log.size()));
        for (int i = 0; i < dut_log.size() && i < mdl_log.size(); i++)
            check_eq("log_byte", 32'(dut_log[i]), 32'(mdl_log[i]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
